cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
- FIFO_DEPTH, 2, entries per source queue.
- NSRC, 2, number of producers (0 = ALU, 1 = LSB).

REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset.
- rdy, in, 1, global enable; low freezes all state.
- rollback, in, 1, mispredict flush.
- alu_done, in, 1, ALU result valid.
- alu_rob_pos, in, ROB_WID, ALU result tag.
- alu_res, in, DATA_WID, ALU result value.
- alu_acpt, out, 1, ALU queue can take a result this cycle.
- lsb_done, in, 1, LSB result valid.
- lsb_rob_pos, in, ROB_WID, LSB result tag.
- lsb_res, in, DATA_WID, LSB result value.
- lsb_acpt, out, 1, LSB queue can take a result this cycle.
- cdb_en, out, 1, broadcast valid.
- cdb_rob_pos, out, ROB_WID, broadcast tag.
- cdb_val, out, DATA_WID, broadcast value.
- cdb_src, out, 1, source of current broadcast (0 = ALU, 1 = LSB).

REQ-003 SHALL use reset rst, synchronous, active-high, and clock clk.

Function
REQ-004 SHALL serialise ALU and LSB results onto one common data bus (CDB), one broadcast per cycle.
REQ-005 SHALL keep one FIFO_DEPTH-entry in-order queue per source; each entry holds {rob_pos, value}.
REQ-006 SHALL drive x_acpt = (queue count < FIFO_DEPTH), computed from registered count only, with no same-cycle pop credit.
REQ-007 SHALL push an entry when x_done && x_acpt && rdy && !rollback, sampled at the rising edge.
- x_done while !x_acpt SHALL be dropped.
- The sequence SHALL be flagged as a protocol violation (assertion).
REQ-008 SHALL treat a source as eligible when its queue is non-empty, or when the queue is empty and x_done=1 (bypass).
- Eligible data SHALL be the queue head, else the bypass input.
REQ-009 SHALL arbitrate round-robin with a 1-bit priority pointer prio.
- If only one source is eligible, that source SHALL win.
- If both are eligible, source prio SHALL win.
- After each grant, prio SHALL become the non-granted source.
- With no grant, prio SHALL hold.
REQ-010 SHALL register the winner into cdb_en/cdb_rob_pos/cdb_val/cdb_src at the same edge.
- Latency: done in cycle N gives cdb_en=1 in cycle N+1 when the source wins.
- A loss SHALL add 1 cycle per lost arbitration round.
REQ-011 SHALL pop the granted queue head at the grant edge; a bypassed grant SHALL not be enqueued.
REQ-012 SHALL allow a simultaneous push and pop on the same queue; count SHALL then be unchanged.
REQ-013 SHALL drive cdb_en=0 in any cycle following an edge with no eligible source; tag and value outputs SHALL hold their prior values.
REQ-014 SHALL broadcast each accepted result exactly once, and SHALL keep per-source order.
REQ-015 SHALL handle rollback as follows:
- Clear both queues.
- Set cdb_en=0 in the next cycle.
- Ignore same-cycle x_done.
- Keep prio unchanged.
REQ-016 SHALL freeze all state and outputs while rdy=0; x_done during rdy=0 SHALL be ignored.
REQ-017 SHALL use queue pointers of width clog2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH; count SHALL be clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-018 SHALL, on rst=1 at an edge, set:
- Queues empty (pointers and counts 0).
- prio = 0 (ALU first).
- cdb_en=0, cdb_rob_pos=0, cdb_val=0, cdb_src=0.
REQ-019 SHALL make rst override rollback and rdy.
REQ-020 SHALL make reset mid-operation discard all queued results.
REQ-021 SHALL output alu_acpt=lsb_acpt=1 in the cycle after reset.

Structure
REQ-022 SHALL take DATA_WID, ROB_WID and new constants CDB_SRC_ALU=0 and CDB_SRC_LSB=1 from shared def.v.
REQ-023 SHALL instantiate sub-module cdb_fifo once per source.
- cdb_fifo is parameterised by depth and width.
- Ports: push, pop, flush, head, count.
REQ-024 SHALL keep the arbitration and bypass logic in cdb_arbiter; target size is 150-300 RTL lines total.

Verification
REQ-025 Single ALU result: alu_done, tag 3, value 0x11 in cycle 0 -> cdb_en=1, tag 3, value 0x11, src 0 in cycle 1; cdb_en=0 in cycle 2.
REQ-026 Contention: ALU (tag 1, 0xA) and LSB (tag 2, 0xB) in cycle 0 after reset -> ALU broadcast in cycle 1, LSB in cycle 2, prio=1.
REQ-027 Fill/backpressure: LSB results every cycle with ALU also busy (ALU results every cycle) -> lsb_acpt falls when the LSB queue holds 2; no loss; LSB order preserved (tags 4, 5, 6).
REQ-028 Rollback with both queues holding 2 entries -> cdb_en=0 next cycle, both acpt=1, no stale tag ever broadcast.
REQ-029 rdy=0 for 3 cycles with cdb_en=1, tag 7 -> outputs and queues frozen; tag 7 broadcast is not repeated after rdy returns.
REQ-030 Reset asserted with 3 results queued -> all outputs 0 next cycle; no queued tag ever appears on the CDB.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: bus widths, source
// encodings and the queue entry layout.
package cdb_arbiter_pkg;

  localparam int DATA_WID = 32;
  localparam int ROB_WID  = 5;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  // One queued result: the ROB tag it completes and the produced value.
  typedef struct packed {
    logic [ROB_WID-1:0]  rob_pos;
    logic [DATA_WID-1:0] value;
  } cdb_entry_t;

  localparam int ENTRY_WID = ROB_WID + DATA_WID;

endpackage

// File: rtl/cdb_arbiter_chk.sv
// Protocol checker: a producer must not offer a result while its queue is
// full, since such a result is silently dropped.
module cdb_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic rdy,
  input logic rollback,
  input logic alu_done,
  input logic alu_acpt,
  input logic lsb_done,
  input logic lsb_acpt
);

  a_alu_no_drop: assert property (@(posedge clk) disable iff (rst)
    (rdy && !rollback && alu_done) |-> alu_acpt);

  a_lsb_no_drop: assert property (@(posedge clk) disable iff (rst)
    (rdy && !rollback && lsb_done) |-> lsb_acpt);

endmodule

// File: rtl/cdb_fifo.sv
// Small in-order result queue. Pointers wrap modulo DEPTH; flush empties the
// queue without touching storage. All state holds while en is low.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Advance a pointer, wrapping at DEPTH even when DEPTH is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers: synchronous reset, frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en) begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results, picks one per cycle
// with a round-robin pointer (empty queues may be bypassed) and registers the
// winner onto the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int NSRC       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                alu_done,
  input  logic [ROB_WID-1:0]  alu_rob_pos,
  input  logic [DATA_WID-1:0] alu_res,
  output logic                alu_acpt,
  input  logic                lsb_done,
  input  logic [ROB_WID-1:0]  lsb_rob_pos,
  input  logic [DATA_WID-1:0] lsb_res,
  output logic                lsb_acpt,
  output logic                cdb_en,
  output logic [ROB_WID-1:0]  cdb_rob_pos,
  output logic [DATA_WID-1:0] cdb_val,
  output logic                cdb_src
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  cdb_entry_t alu_in_s, lsb_in_s, alu_head_s, lsb_head_s, win_s;
  logic [CNT_W-1:0] alu_cnt_s, lsb_cnt_s;
  logic alu_elig_s, lsb_elig_s, gnt_vld_s, gnt_src_s;
  logic alu_push_s, alu_pop_s, alu_byp_s;
  logic lsb_push_s, lsb_pop_s, lsb_byp_s;

  logic                cdb_en_q, cdb_en_d;
  logic [ROB_WID-1:0]  cdb_rob_pos_q, cdb_rob_pos_d;
  logic [DATA_WID-1:0] cdb_val_q, cdb_val_d;
  logic                cdb_src_q, cdb_src_d;
  logic                prio_q, prio_d;

  assign alu_in_s = {alu_rob_pos, alu_res};
  assign lsb_in_s = {lsb_rob_pos, lsb_res};

  // Acceptance looks at registered occupancy only; a same-cycle pop gives no credit.
  assign alu_acpt = (alu_cnt_s < CNT_W'(FIFO_DEPTH));
  assign lsb_acpt = (lsb_cnt_s < CNT_W'(FIFO_DEPTH));

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_WID)) u_alu_fifo (
    .clk(clk), .rst(rst), .en(rdy),
    .push(alu_push_s), .pop(alu_pop_s), .flush(rollback),
    .din(alu_in_s), .head(alu_head_s), .count(alu_cnt_s)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_WID)) u_lsb_fifo (
    .clk(clk), .rst(rst), .en(rdy),
    .push(lsb_push_s), .pop(lsb_pop_s), .flush(rollback),
    .din(lsb_in_s), .head(lsb_head_s), .count(lsb_cnt_s)
  );

  cdb_arbiter_chk u_chk (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_done(alu_done), .alu_acpt(alu_acpt),
    .lsb_done(lsb_done), .lsb_acpt(lsb_acpt)
  );

  // Eligibility, round-robin pick, winner data and queue push/pop control.
  always_comb begin
    alu_elig_s = (alu_cnt_s != '0) || alu_done;
    lsb_elig_s = (lsb_cnt_s != '0) || lsb_done;
    if (alu_elig_s && lsb_elig_s) begin
      gnt_src_s = prio_q;
    end else if (lsb_elig_s) begin
      gnt_src_s = CDB_SRC_LSB;
    end else begin
      gnt_src_s = CDB_SRC_ALU;
    end
    gnt_vld_s = (alu_elig_s || lsb_elig_s) && !rollback;
    if (gnt_src_s == CDB_SRC_LSB) begin
      win_s = (lsb_cnt_s != '0) ? lsb_head_s : lsb_in_s;
    end else begin
      win_s = (alu_cnt_s != '0) ? alu_head_s : alu_in_s;
    end
    alu_pop_s  = gnt_vld_s && (gnt_src_s == CDB_SRC_ALU) && (alu_cnt_s != '0);
    lsb_pop_s  = gnt_vld_s && (gnt_src_s == CDB_SRC_LSB) && (lsb_cnt_s != '0);
    alu_byp_s  = gnt_vld_s && (gnt_src_s == CDB_SRC_ALU) && (alu_cnt_s == '0);
    lsb_byp_s  = gnt_vld_s && (gnt_src_s == CDB_SRC_LSB) && (lsb_cnt_s == '0);
    alu_push_s = alu_done && alu_acpt && !rollback && !alu_byp_s;
    lsb_push_s = lsb_done && lsb_acpt && !rollback && !lsb_byp_s;
  end

  // Next broadcast and priority; tag/value hold when nothing is granted.
  always_comb begin
    cdb_rob_pos_d = cdb_rob_pos_q;
    cdb_val_d     = cdb_val_q;
    cdb_src_d     = cdb_src_q;
    prio_d        = prio_q;
    if (gnt_vld_s) begin
      cdb_en_d      = 1'b1;
      cdb_rob_pos_d = win_s.rob_pos;
      cdb_val_d     = win_s.value;
      cdb_src_d     = gnt_src_s;
      prio_d        = ~gnt_src_s;
    end else begin
      cdb_en_d = 1'b0;
    end
  end

  // Output and priority registers: reset dominates, rdy low freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_en_q      <= 1'b0;
      cdb_rob_pos_q <= '0;
      cdb_val_q     <= '0;
      cdb_src_q     <= CDB_SRC_ALU;
      prio_q        <= CDB_SRC_ALU;
    end else if (rdy) begin
      cdb_en_q      <= cdb_en_d;
      cdb_rob_pos_q <= cdb_rob_pos_d;
      cdb_val_q     <= cdb_val_d;
      cdb_src_q     <= cdb_src_d;
      prio_q        <= prio_d;
    end
  end

  assign cdb_en      = cdb_en_q;
  assign cdb_rob_pos = cdb_rob_pos_q;
  assign cdb_val     = cdb_val_q;
  assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, checked
// against a queue-based model of the arbitration rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int OW    = 2 + ROB_WID + DATA_WID;

  logic clk = 1'b0;
  logic rst = 1'b1, rdy = 1'b0, rollback = 1'b0;
  logic alu_done = 1'b0, lsb_done = 1'b0;
  logic [ROB_WID-1:0]  alu_rob_pos = '0, lsb_rob_pos = '0;
  logic [DATA_WID-1:0] alu_res = '0, lsb_res = '0;
  logic alu_acpt, lsb_acpt, cdb_en, cdb_src;
  logic [ROB_WID-1:0]  cdb_rob_pos;
  logic [DATA_WID-1:0] cdb_val;

  int errors = 0;
  int checks = 0;

  // Reference model: per-source result queues plus the visible bus state.
  logic [ENTRY_WID-1:0] alu_q[$];
  logic [ENTRY_WID-1:0] lsb_q[$];
  logic m_prio, m_en, m_src;
  logic [ROB_WID-1:0]  m_rob;
  logic [DATA_WID-1:0] m_val;
  logic [1:0] pre_acpt_obs, pre_acpt_exp;

  wire [OW-1:0] obs_w = {cdb_en, cdb_src, cdb_rob_pos, cdb_val};
  wire [OW-1:0] exp_w = {m_en, m_src, m_rob, m_val};

  always #5 clk = ~clk;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .NSRC(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_done(alu_done), .alu_rob_pos(alu_rob_pos), .alu_res(alu_res), .alu_acpt(alu_acpt),
    .lsb_done(lsb_done), .lsb_rob_pos(lsb_rob_pos), .lsb_res(lsb_res), .lsb_acpt(lsb_acpt),
    .cdb_en(cdb_en), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b0; rollback = 1'b1; alu_done = 1'b1; lsb_done = 1'b1;
    @(posedge clk); #1;
    alu_q.delete(); lsb_q.delete();
    m_prio = 1'b0; m_en = 1'b0; m_src = 1'b0; m_rob = '0; m_val = '0;
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; alu_done = 1'b0; lsb_done = 1'b0;
  endtask

  // One clock of stimulus; offers are withheld when the model says the queue is full.
  task automatic cycle(input logic ad, input logic [ROB_WID-1:0] at, input logic [DATA_WID-1:0] av,
                       input logic ld, input logic [ROB_WID-1:0] lt, input logic [DATA_WID-1:0] lv,
                       input logic rd, input logic rb);
    logic ad_g, ld_g, ae, le, win;
    logic [ENTRY_WID-1:0] e;
    pre_acpt_exp = {alu_q.size() < DEPTH, lsb_q.size() < DEPTH};
    ad_g = ad && pre_acpt_exp[1];
    ld_g = ld && pre_acpt_exp[0];
    alu_done = ad_g; alu_rob_pos = at; alu_res = av;
    lsb_done = ld_g; lsb_rob_pos = lt; lsb_res = lv;
    rdy = rd; rollback = rb;
    #1;
    pre_acpt_obs = {alu_acpt, lsb_acpt};
    if (rd) begin
      if (rb) begin
        alu_q.delete(); lsb_q.delete(); m_en = 1'b0;
      end else begin
        if (ad_g) alu_q.push_back({at, av});
        if (ld_g) lsb_q.push_back({lt, lv});
        ae = alu_q.size() != 0;
        le = lsb_q.size() != 0;
        if (ae || le) begin
          win = (ae && le) ? m_prio : le;
          if (win) e = lsb_q.pop_front();
          else     e = alu_q.pop_front();
          m_en = 1'b1; m_src = win; {m_rob, m_val} = e; m_prio = ~win;
        end else begin
          m_en = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (obs_w !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", obs_w); end
    checks++; if ({alu_acpt, lsb_acpt} !== 2'b11) begin errors++; $display("FAIL reset_acpt: got %b want 11", {alu_acpt, lsb_acpt}); end
  endtask

  task automatic test_single();
    do_reset();
    cycle(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (obs_w !== {1'b1, 1'b0, 5'd3, 32'h11}) begin errors++; $display("FAIL single_bcast: got %h want tag3/11/alu", obs_w); end
    idle();
    checks++; if (cdb_en !== 1'b0) begin errors++; $display("FAIL single_idle_en: got %b want 0", cdb_en); end
    checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL single_hold: got %h want %h", obs_w, exp_w); end
  endtask

  task automatic test_contention();
    do_reset();
    cycle(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b1, 1'b0);
    checks++; if (obs_w !== {1'b1, 1'b0, 5'd1, 32'hA}) begin errors++; $display("FAIL cont_alu_first: got %h", obs_w); end
    // prio now points at LSB: a fresh ALU result must lose to the queued LSB one
    cycle(1'b1, 5'd9, 32'hC, 1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (obs_w !== {1'b1, 1'b1, 5'd2, 32'hB}) begin errors++; $display("FAIL cont_lsb_second: got %h", obs_w); end
    idle();
    checks++; if (obs_w !== {1'b1, 1'b0, 5'd9, 32'hC}) begin errors++; $display("FAIL cont_alu_third: got %h", obs_w); end
  endtask

  task automatic test_backpressure();
    logic [ROB_WID-1:0] seen[$];
    int next_tag = 4;
    bit saw_full = 1'b0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i < 8) cycle(1'b1, ROB_WID'(16 + i), 32'(i), 1'b1, ROB_WID'(next_tag), 32'(100 + next_tag), 1'b1, 1'b0);
      else       idle();
      if (i < 8 && pre_acpt_exp[0]) next_tag++;
      if (pre_acpt_obs[0] === 1'b0) saw_full = 1'b1;
      if (cdb_en === 1'b1 && cdb_src === 1'b1) seen.push_back(cdb_rob_pos);
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL bp_out[%0d]: got %h want %h", i, obs_w, exp_w); end
      checks++; if (pre_acpt_obs !== pre_acpt_exp) begin errors++; $display("FAIL bp_acpt[%0d]: got %b want %b", i, pre_acpt_obs, pre_acpt_exp); end
    end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_lsb_full: lsb_acpt never dropped"); end
    checks++; if (seen.size() !== next_tag - 4) begin errors++; $display("FAIL bp_count: got %0d want %0d", seen.size(), next_tag - 4); end
    for (int k = 0; k < 3 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== ROB_WID'(4 + k)) begin errors++; $display("FAIL bp_order[%0d]: got %0d want %0d", k, seen[k], 4 + k); end
    end
  endtask

  task automatic test_rollback();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, ROB_WID'(10 + i), 32'(i), 1'b1, ROB_WID'(20 + i), 32'(i), 1'b1, 1'b0);
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL rb_fill[%0d]: got %h want %h", i, obs_w, exp_w); end
    end
    checks++; if ({alu_acpt, lsb_acpt} === 2'b11) begin errors++; $display("FAIL rb_full: got acpt %b want a full queue", {alu_acpt, lsb_acpt}); end
    cycle(1'b1, 5'd30, 32'h30, 1'b1, 5'd31, 32'h31, 1'b1, 1'b1);
    checks++; if (cdb_en !== 1'b0) begin errors++; $display("FAIL rb_en: got %b want 0", cdb_en); end
    checks++; if ({alu_acpt, lsb_acpt} !== 2'b11) begin errors++; $display("FAIL rb_acpt: got %b want 11", {alu_acpt, lsb_acpt}); end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (cdb_en !== 1'b0) begin errors++; $display("FAIL rb_stale[%0d]: got en=%b tag=%0d", i, cdb_en, cdb_rob_pos); end
    end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0);
    checks++; if (obs_w !== {1'b1, 1'b0, 5'd7, 32'h77}) begin errors++; $display("FAIL frz_first: got %h", obs_w); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b0, 1'b0);
      checks++; if (obs_w !== {1'b1, 1'b0, 5'd7, 32'h77}) begin errors++; $display("FAIL frz_hold[%0d]: got %h", i, obs_w); end
      checks++; if ({alu_acpt, lsb_acpt} !== 2'b11) begin errors++; $display("FAIL frz_acpt[%0d]: got %b want 11", i, {alu_acpt, lsb_acpt}); end
    end
    idle();
    checks++; if (obs_w !== {1'b1, 1'b1, 5'd8, 32'h88}) begin errors++; $display("FAIL frz_resume: got %h want tag8/lsb", obs_w); end
    idle();
    checks++; if (cdb_en !== 1'b0) begin errors++; $display("FAIL frz_norepeat: got en=%b tag=%0d", cdb_en, cdb_rob_pos); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, ROB_WID'(1 + i), 32'(i), 1'b1, ROB_WID'(11 + i), 32'(i), 1'b1, 1'b0);
    do_reset();
    checks++; if (obs_w !== '0) begin errors++; $display("FAIL rmid_out: got %h want 0", obs_w); end
    checks++; if ({alu_acpt, lsb_acpt} !== 2'b11) begin errors++; $display("FAIL rmid_acpt: got %b want 11", {alu_acpt, lsb_acpt}); end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (cdb_en !== 1'b0) begin errors++; $display("FAIL rmid_stale[%0d]: got tag %0d", i, cdb_rob_pos); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), ROB_WID'($urandom), $urandom,
            1'($urandom_range(0, 1)), ROB_WID'($urandom), $urandom,
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0));
      checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL rand_out[%0d]: got %h want %h", i, obs_w, exp_w); end
      checks++; if (pre_acpt_obs !== pre_acpt_exp) begin errors++; $display("FAIL rand_acpt[%0d]: got %b want %b", i, pre_acpt_obs, pre_acpt_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_rollback();
    test_rdy_freeze();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
